spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_rr_arbiter.sv | 44 ++++
 rtl/spi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM encoding, descriptor
// field widths and default timeout budgets.
package spi_pkg;

  localparam int MODE_W = 2;
  localparam int CMD_W  = 6;
  localparam int LEN_W  = 10;

  localparam int DEF_START_TO = 4096;
  localparam int DEF_XFER_TO  = 2_000_000;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_BUSY    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic              clk_ss;
    logic [CMD_W-1:0]  cmd_len;
    logic [LEN_W-1:0]  send_len;
    logic [CMD_W-1:0]  resp_len;
    logic [LEN_W-1:0]  recv_len;
  } spi_desc_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin one-hot picker: searches upward from ptr, and moves ptr just
// past the winner when the caller commits a grant.
module spi_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among N requesters: round-robin grant, descriptor
// latching, start/transfer watchdogs and master reset on timeout.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N        = 3,
  parameter int START_TO = DEF_START_TO,
  parameter int XFER_TO  = DEF_XFER_TO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [MODE_W*N-1:0]  req_mode,
  input  logic [N-1:0]         req_clk_ss,
  input  logic [CMD_W*N-1:0]   req_cmd_len,
  input  logic [LEN_W*N-1:0]   req_send_len,
  input  logic [CMD_W*N-1:0]   req_resp_len,
  input  logic [LEN_W*N-1:0]   req_recv_len,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         done,
  output logic [N-1:0]         err,
  output logic                 spi_start,
  output logic [MODE_W-1:0]    spi_mode,
  output logic                 spi_clk_ss,
  output logic [CMD_W-1:0]     spi_cmd_len,
  output logic [LEN_W-1:0]     spi_send_len,
  output logic [CMD_W-1:0]     spi_resp_len,
  output logic [LEN_W-1:0]     spi_recv_len,
  output logic                 spi_rst,
  input  logic                 spi_busy,
  input  logic                 spi_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(XFER_TO + 1);

  logic [2:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic          start_q, start_d, srst_q, srst_d;
  spi_desc_t     desc_q, desc_d, pick_desc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_prev_q, valid_prev_q;
  logic          adv, xfer_end;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;

  spi_rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .adv_i (adv),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    pick_desc.mode     = req_mode[int'(pick_idx)*MODE_W +: MODE_W];
    pick_desc.clk_ss   = req_clk_ss[pick_idx];
    pick_desc.cmd_len  = req_cmd_len[int'(pick_idx)*CMD_W +: CMD_W];
    pick_desc.send_len = req_send_len[int'(pick_idx)*LEN_W +: LEN_W];
    pick_desc.resp_len = req_resp_len[int'(pick_idx)*CMD_W +: CMD_W];
    pick_desc.recv_len = req_recv_len[int'(pick_idx)*LEN_W +: LEN_W];
  end

  // Either status edge marks the end of a transfer; it outranks a watchdog expiry.
  assign xfer_end = (spi_valid & ~valid_prev_q) | (~spi_busy & busy_prev_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    start_d = start_q;
    srst_d  = 1'b0;
    desc_d  = desc_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          adv     = 1'b1;
          gnt_d   = pick_gnt;
          desc_d  = pick_desc;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (spi_busy) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end else if (cnt_q == CW'(START_TO - 1)) begin
          err_d   = gnt_q;
          start_d = 1'b0;
          srst_d  = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BUSY: begin
        if (xfer_end) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(XFER_TO - 1)) begin
          err_d   = gnt_q;
          srst_d  = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_RECOVER: begin
        // Two cycles with nobody granted while the master comes out of reset.
        if (cnt_q == CW'(1)) state_d = S_IDLE;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      start_q      <= 1'b0;
      srst_q       <= 1'b0;
      desc_q       <= '0;
      cnt_q        <= '0;
      busy_prev_q  <= 1'b0;
      valid_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_q      <= start_d;
      srst_q       <= srst_d;
      desc_q       <= desc_d;
      cnt_q        <= cnt_d;
      busy_prev_q  <= spi_busy;
      valid_prev_q <= spi_valid;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign spi_start    = start_q;
  assign spi_rst      = srst_q;
  assign spi_mode     = desc_q.mode;
  assign spi_clk_ss   = desc_q.clk_ss;
  assign spi_cmd_len  = desc_q.cmd_len;
  assign spi_send_len = desc_q.send_len;
  assign spi_resp_len = desc_q.resp_len;
  assign spi_recv_len = desc_q.recv_len;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: instance A keeps the default timeouts, instance B uses
// short ones; only one is out of reset at a time and sel_b picks the one observed.
`timescale 1ns/1ps
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam int N  = 3;
  localparam int DW = $bits(spi_desc_t);
  localparam int OW = 3 * N + 2 + DW;
  localparam int B_START_TO = 16;
  localparam int B_XFER_TO  = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_a, rst_b, sel_b;
  logic [N-1:0]        req;
  logic [MODE_W*N-1:0] req_mode;
  logic [N-1:0]        req_clk_ss;
  logic [CMD_W*N-1:0]  req_cmd_len, req_resp_len;
  logic [LEN_W*N-1:0]  req_send_len, req_recv_len;
  logic                spi_busy, spi_valid;

  logic [N-1:0]        gnt_a, done_a, err_a, gnt_b, done_b, err_b;
  logic                start_a, srst_a, ss_a, start_b, srst_b, ss_b;
  logic [MODE_W-1:0]   mode_a, mode_b;
  logic [CMD_W-1:0]    cmd_a, resp_a, cmd_b, resp_b;
  logic [LEN_W-1:0]    send_a, recv_a, send_b, recv_b;

  spi_arbiter #(.N(N)) dut_a (
    .clk(clk), .rst(rst_a), .req(req), .req_mode(req_mode), .req_clk_ss(req_clk_ss),
    .req_cmd_len(req_cmd_len), .req_send_len(req_send_len), .req_resp_len(req_resp_len),
    .req_recv_len(req_recv_len), .gnt(gnt_a), .done(done_a), .err(err_a),
    .spi_start(start_a), .spi_mode(mode_a), .spi_clk_ss(ss_a), .spi_cmd_len(cmd_a),
    .spi_send_len(send_a), .spi_resp_len(resp_a), .spi_recv_len(recv_a),
    .spi_rst(srst_a), .spi_busy(spi_busy), .spi_valid(spi_valid)
  );

  spi_arbiter #(.N(N), .START_TO(B_START_TO), .XFER_TO(B_XFER_TO)) dut_b (
    .clk(clk), .rst(rst_b), .req(req), .req_mode(req_mode), .req_clk_ss(req_clk_ss),
    .req_cmd_len(req_cmd_len), .req_send_len(req_send_len), .req_resp_len(req_resp_len),
    .req_recv_len(req_recv_len), .gnt(gnt_b), .done(done_b), .err(err_b),
    .spi_start(start_b), .spi_mode(mode_b), .spi_clk_ss(ss_b), .spi_cmd_len(cmd_b),
    .spi_send_len(send_b), .spi_resp_len(resp_b), .spi_recv_len(recv_b),
    .spi_rst(srst_b), .spi_busy(spi_busy), .spi_valid(spi_valid)
  );

  logic [OW-1:0] obs_a, obs_b, obs;
  logic [N-1:0]  gnt, done, err;
  logic          spi_start, spi_rst;
  spi_desc_t     desc;

  assign obs_a = {gnt_a, done_a, err_a, start_a, srst_a, mode_a, ss_a, cmd_a, send_a, resp_a, recv_a};
  assign obs_b = {gnt_b, done_b, err_b, start_b, srst_b, mode_b, ss_b, cmd_b, send_b, resp_b, recv_b};
  assign obs   = sel_b ? obs_b : obs_a;
  assign {gnt, done, err, spi_start, spi_rst, desc} = obs;

  int        n_checks = 0;
  int        n_pass   = 0;
  int        n_fail   = 0;
  int        m_ptr    = 0;
  spi_desc_t dsc [N];

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic drive_desc();
    for (int i = 0; i < N; i++) begin
      req_mode[i*MODE_W +: MODE_W]    = dsc[i].mode;
      req_clk_ss[i]                   = dsc[i].clk_ss;
      req_cmd_len[i*CMD_W +: CMD_W]   = dsc[i].cmd_len;
      req_send_len[i*LEN_W +: LEN_W]  = dsc[i].send_len;
      req_resp_len[i*CMD_W +: CMD_W]  = dsc[i].resp_len;
      req_recv_len[i*LEN_W +: LEN_W]  = dsc[i].recv_len;
    end
  endtask

  task automatic randomize_desc();
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      r = {$urandom, $urandom};
      dsc[i] = r[DW-1:0];
    end
    drive_desc();
  endtask

  // Waits (bounded) for a grant and checks it and the latched descriptor against the model.
  task automatic wait_grant(output int w, output spi_desc_t ed);
    int n;
    n = 0;
    w = rr_pick(req, m_ptr);
    ed = dsc[w];
    while (gnt === '0 && n < 8) begin
      tick();
      n++;
    end
    check("grant", gnt, N'(1) << w);
    check("start_hi", spi_start, 1);
    check("desc_latch", desc, ed);
    m_ptr = (w + 1) % N;
  endtask

  task automatic run_xfer(input int sdly, input int xdly, input bit by_valid,
                          input bit drop_early, input logic [N-1:0] late, output int w);
    logic [N-1:0] g;
    spi_desc_t    ed;
    bit           held;
    wait_grant(w, ed);
    g = N'(1) << w;
    randomize_desc();
    held = 1'b1;
    repeat (sdly) begin
      tick();
      held &= (spi_start === 1'b1) && (desc === ed) && (gnt === g);
    end
    spi_busy = 1'b1;
    tick();
    check("start_drop", spi_start, 0);
    req = req | (late & ~g);
    if (drop_early) req = req & ~g;
    repeat (xdly) begin
      tick();
      held &= (desc === ed) && (gnt === g) && (done === '0) && (err === '0) && (spi_start === 1'b0);
    end
    if (by_valid) spi_valid = 1'b1;
    else          spi_busy  = 1'b0;
    tick();
    check("done", done, g);
    check("gnt_err_after_done", {gnt, err, spi_rst}, 0);
    check("hold_during_xfer", held, 1);
    req       = req & ~g;
    spi_busy  = 1'b0;
    spi_valid = 1'b0;
    tick();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int        w;
    bit        held;
    spi_desc_t ed;
    rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
    req = '0; spi_busy = 1'b0; spi_valid = 1'b0;
    randomize_desc();
    repeat (3) tick();
    check("reset_a", obs_a, 0);
    check("reset_b", obs_b, 0);

    rst_a = 1'b0;
    tick();
    check("idle_quiet", {gnt, done, err, spi_start, spi_rst}, 0);

    // Single request, cmd=6 resp=1; busy 30 cycles after start, valid 500 after busy.
    dsc[0].cmd_len  = 6'd6;
    dsc[0].resp_len = 6'd1;
    drive_desc();
    req = 3'b001;
    run_xfer(30, 499, 1'b1, 1'b0, '0, w);
    check("single_who", w, 0);

    // Contention from a fresh pointer: 0,1,2 then the next round opens with 0.
    rst_a = 1'b1; tick(); rst_a = 1'b0; m_ptr = 0;
    req = 3'b111;
    run_xfer(2, 5, 1'b0, 1'b0, '0, w); check("order_1st", w, 0);
    run_xfer(1, 3, 1'b1, 1'b0, '0, w); check("order_2nd", w, 1);
    run_xfer(0, 4, 1'b0, 1'b0, '0, w); check("order_3rd", w, 2);
    req = 3'b111;
    run_xfer(3, 2, 1'b1, 1'b0, '0, w); check("order_round2", w, 0);

    // Random traffic: late arrivals wait, early drops still complete.
    for (int it = 0; it < 10; it++) begin
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      run_xfer($urandom_range(0, 12), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), N'($urandom_range(0, (1 << N) - 1)), w);
    end

    // Zero-length command is forwarded untouched.
    req = '0;
    tick(); tick();
    dsc[2].cmd_len = '0;
    drive_desc();
    req = 3'b100;
    run_xfer(1, 2, 1'b0, 1'b0, '0, w);

    // Reset in the middle of BUSY: everything back to zero, pointer back to 0.
    rst_a = 1'b1; tick(); rst_a = 1'b0; m_ptr = 0;
    req = 3'b010;
    tick();
    check("pre_rst_grant", gnt, 3'b010);
    spi_busy = 1'b1;
    tick(); tick(); tick();
    rst_a = 1'b1;
    req = 3'b111;
    tick();
    check("rst_mid_busy", obs_a, 0);
    rst_a = 1'b0;
    spi_busy = 1'b0;
    m_ptr = 0;
    tick();
    check("rst_no_pulse_ptr0", {gnt, done, err}, {3'b001, 6'b0});
    run_xfer(1, 1, 1'b1, 1'b0, '0, w);

    // Switch to the short-timeout instance.
    sel_b = 1'b1; rst_a = 1'b1; req = '0; spi_busy = 1'b0; spi_valid = 1'b0;
    tick();
    rst_b = 1'b0; m_ptr = 0;
    tick();

    // Start timeout: master never raises busy; err lands START_TO cycles after spi_start.
    req = 3'b001;
    wait_grant(w, ed);
    held = 1'b1;
    repeat (B_START_TO - 1) begin
      tick();
      held &= (err === '0) && (spi_start === 1'b1) && (spi_rst === 1'b0);
    end
    check("start_to_wait", held, 1);
    tick();
    check("start_to_err", {err, spi_rst, spi_start, gnt}, {3'b001, 1'b1, 1'b0, 3'b000});
    req = 3'b010;
    tick();
    check("recover_1", {gnt, err, spi_rst, done}, 0);
    tick();
    check("recover_2", gnt, 0);
    // Third cycle after err is the arbitration cycle; the new grant appears after it.
    tick();
    wait_grant(w, ed);
    check("after_recover_who", w, 1);

    // Transfer timeout with busy stuck high; requester 2 queues meanwhile.
    spi_busy = 1'b1;
    req = req | 3'b100;
    held = 1'b1;
    repeat (B_XFER_TO) begin
      tick();
      held &= (err === '0) && (spi_rst === 1'b0) && (done === '0);
    end
    check("xfer_to_wait", held, 1);
    tick();
    check("xfer_to_err", {err, spi_rst, gnt, done}, {3'b010, 1'b1, 3'b000, 3'b000});
    req = req & ~3'b010;
    spi_busy = 1'b0;
    tick();
    check("xfer_to_rst_pulse", spi_rst, 0);
    run_xfer(2, 3, 1'b1, 1'b0, '0, w);
    check("next_served", w, 2);

    // Busy falls in the very cycle the transfer watchdog expires: done wins.
    req = 3'b001;
    wait_grant(w, ed);
    spi_busy = 1'b1;
    repeat (B_XFER_TO) tick();
    spi_busy = 1'b0;
    tick();
    check("tie_done", done, 3'b001);
    check("tie_no_err", {err, spi_rst}, 0);
    req = '0;
    tick();
    check("tie_done_pulse", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
